key_switch_reader: RTL
======================

// Module: key_switch_reader
// PURPOSE
//  Memory-mapped input peripheral that the data-memory path reads for KEY/SW. Synchronises and
//  debounces the raw board pushbuttons and switches, and captures key-press edges in sticky flags.
//  Those flags are cleared by reading the port. Responds on the same word-addressed bus as the
//  output devices (HEX/LEDR/LEDG), serving the input end of the I/O map. Drives a level interrupt.
// PARAMETERS
//  ADDR_KEY            32'hF0000010  byte address of KEY data register (read)
//  ADDR_SW             32'hF0000014  byte address of SW data register (read)
//  ADDR_KCTRL          32'hF0000110  byte address of KEY control/status register (read/write)
//  DMEM_ADDR_BIT_WIDTH 30            word-address width; match on ADDR_x[31:2]
//  DMEM_DATA_BIT_WIDTH 32            bus data width
//  DEBOUNCE_CYCLES     500000        stable cycles required before debounced value changes (>=2)
// PORTS
//  clk     in   1   system clock, all state on rising edge
//  resetN  in   1   asynchronous active-low reset
//  rdEn    in   1   bus read strobe
//  wrtEn   in   1   bus write strobe
//  addr    in   30  word address
//  dIn     in   32  write data
//  key     in   4   raw pushbuttons, active-low (0 = pressed), asynchronous
//  sw      in   10  raw slide switches, active-high, asynchronous
//  sel     out  1   combinational: addr hits one of the three registers
//  dOut    out  32  registered read data
//  intr    out  1   registered interrupt = kIe & kReady
// BEHAVIOUR
//  Reset (resetN=0, async): sync flops, debounced state, counters, keyEdge, kOvr, kIe, dOut and intr all reset to 0.
//   keyState=0 means no key pressed; the key synchroniser resets to 4'hF (released).
//  Sync: 2-flop synchroniser per bit; key inverted after sync -> pressed=1.
//  Debounce, one counter per group (KEY group, SW group), width clog2(DEBOUNCE_CYCLES+1):
//   synced != debounced -> counter increments. Counter reaching DEBOUNCE_CYCLES-1 -> debounced<=synced,
//   counter<=0. synced == debounced -> counter<=0. Any mismatch that returns to equal before the limit
//   restarts the count. A bounce on any bit of the group delays the whole group.
//  Edge capture: keyEdge[i] set on debounced 0->1 of keyState[i]. If keyEdge[i] is already 1 when the
//   new edge arrives -> kOvr set (sticky). kReady = |keyEdge.
//  Read (rdEn & sel), dOut valid the cycle after the strobe (1-cycle latency). dOut holds its value
//   otherwise. Unmapped read -> dOut=0.
//   KEY:   dOut={24'b0, keyEdge[3:0], keyState[3:0]}; keyEdge cleared in that same cycle.
//   SW:    dOut={22'b0, swState[9:0]}; no side effects.
//   KCTRL: dOut={27'b0, kIe, 2'b0, kOvr, kReady}; no side effects.
//  Simultaneous KEY read and new edge on bit i: the returned data shows the old keyEdge[i].
//   keyEdge[i] ends 1 (set wins over clear), so no press is lost.
//  Write (wrtEn & sel), only KCTRL is writable: kIe<=dIn[4]; dIn[1]=1 clears kOvr.
//   The overrun set condition beats a same-cycle clear. Writes to KEY/SW are ignored.
//  rdEn & wrtEn both high: the write is applied; the read returns pre-write state.
//  intr is registered: asserts 1 cycle after kIe&kReady becomes true, deasserts 1 cycle after it clears.
//  Reset mid-debounce clears the counter. After reset release, inputs need full DEBOUNCE_CYCLES + 2 sync cycles.
// TESTING (DEBOUNCE_CYCLES=4)
//  1 Reset: hold resetN=0 with key=4'hF, sw=10'h3FF. Release.
//    -> dOut=0, intr=0 after reset. Read SW at cycle 8 -> 32'h3FF.
//  2 Press: key=4'hE held 10 cycles. Read KEY -> 32'h11.
//    Second KEY read -> 32'h01 (edge cleared, still pressed).
//  3 Bounce: key[1] toggles every 2 cycles for 12 cycles, then released.
//    -> no edge captured; KEY read -> 32'h00.
//  4 Overrun/clear: two debounced presses of key[2] with no read -> KCTRL read 32'h03.
//    Write KCTRL dIn=32'h2 -> read 32'h01.
//  5 Interrupt: write KCTRL 32'h10, then press key[3] -> intr=1.
//    KEY read -> 32'h88; intr=0 within 2 cycles.
//  6 Race: KEY read in the same cycle keyEdge[0] sets.
//    -> dOut[4]=0, following KCTRL read bit0=1.
//    Unmapped read addr=30'h0 -> dOut=0, sel=0.

Source files
------------

// File: rtl/key_switch_reader.sv
// key_switch_reader
//   Memory-mapped input peripheral for the board pushbuttons (KEY) and slide
//   switches (SW). Each raw input is passed through a two-flop synchroniser
//   and then debounced, with one debounce counter for each group. A debounced
//   key press sets a sticky edge flag. Reading the KEY data register clears
//   these flags. A level interrupt is raised while interrupts are enabled and
//   any edge flag is pending.
//
// Ports
//   clk     : system clock, all state on the rising edge
//   resetN  : asynchronous active-low reset
//   rdEn    : bus read strobe
//   wrtEn   : bus write strobe
//   addr    : word address (byte address bits [31:2])
//   dIn     : write data
//   key     : raw pushbuttons, active-low, asynchronous
//   sw      : raw slide switches, active-high, asynchronous
//   sel     : combinational, addr hits KEY, SW or KCTRL
//   dOut    : registered read data, valid the cycle after rdEn
//   intr    : registered interrupt (enable & any edge pending)
module key_switch_reader #(
  parameter logic [31:0] ADDR_KEY            = 32'hF0000010,
  parameter logic [31:0] ADDR_SW             = 32'hF0000014,
  parameter logic [31:0] ADDR_KCTRL          = 32'hF0000110,
  parameter int          DMEM_ADDR_BIT_WIDTH = 30,
  parameter int          DMEM_DATA_BIT_WIDTH = 32,
  parameter int          DEBOUNCE_CYCLES     = 500000
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           rdEn,
  input  logic                           wrtEn,
  input  logic [DMEM_ADDR_BIT_WIDTH-1:0] addr,
  input  logic [DMEM_DATA_BIT_WIDTH-1:0] dIn,
  input  logic [3:0]                     key,
  input  logic [9:0]                     sw,
  output logic                           sel,
  output logic [DMEM_DATA_BIT_WIDTH-1:0] dOut,
  output logic                           intr
);

  localparam int AW = DMEM_ADDR_BIT_WIDTH;
  localparam int DW = DMEM_DATA_BIT_WIDTH;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [AW-1:0] WORD_KEY   = ADDR_KEY[AW+1:2];
  localparam logic [AW-1:0] WORD_SW    = ADDR_SW[AW+1:2];
  localparam logic [AW-1:0] WORD_KCTRL = ADDR_KCTRL[AW+1:2];

  // Key synchroniser bits reset to 1 so the buttons read as released
  localparam logic [13:0] SYNC_RST = {10'h000, 4'hF};

  // ---------------------------------------------------------------
  // Two-flop synchronisers, one per raw input bit ({sw, key})
  // ---------------------------------------------------------------
  logic [13:0] raw_in;
  logic [13:0] synced_raw;

  assign raw_in = {sw, key};

  genvar gi;
  generate
    for (gi = 0; gi < 14; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          s1_reg <= SYNC_RST[gi];
          s2_reg <= SYNC_RST[gi];
        end else begin
          s1_reg <= raw_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign synced_raw[gi] = s2_reg;
    end
  endgenerate

  logic [3:0] key_synced;
  logic [9:0] sw_synced;

  // Keys become pressed-high after synchronisation
  assign key_synced = ~synced_raw[3:0];
  assign sw_synced  = synced_raw[13:4];

  // ---------------------------------------------------------------
  // Debounce: the group's debounced value follows the synchronised
  // value once it has disagreed for DEBOUNCE_CYCLES consecutive
  // cycles. Any bit bouncing back to agreement restarts the group.
  // ---------------------------------------------------------------
  logic [3:0]    key_state_reg, key_state_next;
  logic [CW-1:0] key_cnt_reg, key_cnt_next;
  logic [9:0]    sw_state_reg, sw_state_next;
  logic [CW-1:0] sw_cnt_reg, sw_cnt_next;

  always_comb begin
    key_cnt_next   = '0;
    key_state_next = key_state_reg;
    if (key_synced != key_state_reg) begin
      if (key_cnt_reg == CNT_LAST) begin
        key_state_next = key_synced;
      end else begin
        key_cnt_next = key_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    sw_cnt_next   = '0;
    sw_state_next = sw_state_reg;
    if (sw_synced != sw_state_reg) begin
      if (sw_cnt_reg == CNT_LAST) begin
        sw_state_next = sw_synced;
      end else begin
        sw_cnt_next = sw_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Bus decode, edge capture, control register and read data
  // ---------------------------------------------------------------
  logic hit_key, hit_sw, hit_kctrl;
  logic rd_key, wr_kctrl;

  assign hit_key   = (addr == WORD_KEY);
  assign hit_sw    = (addr == WORD_SW);
  assign hit_kctrl = (addr == WORD_KCTRL);
  assign sel       = hit_key | hit_sw | hit_kctrl;
  assign rd_key    = rdEn & hit_key;
  assign wr_kctrl  = wrtEn & hit_kctrl;

  logic [3:0]    key_edge_reg, key_edge_next;
  logic [3:0]    key_rise;
  logic          key_ready;
  logic          ovr_reg, ovr_next;
  logic          ie_reg, ie_next;
  logic [DW-1:0] dout_reg, dout_next;
  logic          intr_reg, intr_next;

  assign key_rise  = key_state_next & ~key_state_reg;
  assign key_ready = |key_edge_reg;

  always_comb begin
    // A new edge wins over the clear from a KEY read, so no press is lost
    key_edge_next = (rd_key ? 4'h0 : key_edge_reg) | key_rise;
    // Overrun set beats a same-cycle software clear
    ovr_next  = (ovr_reg & ~(wr_kctrl & dIn[1])) | (|(key_rise & key_edge_reg));
    ie_next   = wr_kctrl ? dIn[4] : ie_reg;
    intr_next = ie_reg & key_ready;

    // Read data comes from pre-update state; unmapped reads return 0
    dout_next = dout_reg;
    if (rdEn) begin
      dout_next = '0;
      if (hit_key) begin
        dout_next = DW'({key_edge_reg, key_state_reg});
      end else if (hit_sw) begin
        dout_next = DW'(sw_state_reg);
      end else if (hit_kctrl) begin
        dout_next = DW'({ie_reg, 2'b00, ovr_reg, key_ready});
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_state_reg <= '0;
      key_cnt_reg   <= '0;
      sw_state_reg  <= '0;
      sw_cnt_reg    <= '0;
      key_edge_reg  <= '0;
      ovr_reg       <= 1'b0;
      ie_reg        <= 1'b0;
      dout_reg      <= '0;
      intr_reg      <= 1'b0;
    end else begin
      key_state_reg <= key_state_next;
      key_cnt_reg   <= key_cnt_next;
      sw_state_reg  <= sw_state_next;
      sw_cnt_reg    <= sw_cnt_next;
      key_edge_reg  <= key_edge_next;
      ovr_reg       <= ovr_next;
      ie_reg        <= ie_next;
      dout_reg      <= dout_next;
      intr_reg      <= intr_next;
    end
  end

  assign dOut = dout_reg;
  assign intr = intr_reg;

endmodule
